// File: rtl/cr16_pkg.sv
// Shared definitions for the CR16-style ALU issue controller.
//   - 5-bit ALU opcode constants driven on alu_opcode
//   - PSR / ALU flag bit positions inside the {C,L,F,Z,N} vector
//   - instruction op [15:12] and ext [7:4] field encodings
//   - FSM state, operand-source and PSR-update selector types
//   - psr_mask(): which PSR bits an instruction class may modify
package cr16_pkg;

   localparam logic [4:0] ALU_ADD  = 5'h00;
   localparam logic [4:0] ALU_ADDU = 5'h01;
   localparam logic [4:0] ALU_ADDC = 5'h02;
   localparam logic [4:0] ALU_SUB  = 5'h03;
   localparam logic [4:0] ALU_CMP  = 5'h04;
   localparam logic [4:0] ALU_AND  = 5'h05;
   localparam logic [4:0] ALU_OR   = 5'h06;
   localparam logic [4:0] ALU_XOR  = 5'h07;
   localparam logic [4:0] ALU_NOT  = 5'h08;
   localparam logic [4:0] ALU_LSH  = 5'h09;
   localparam logic [4:0] ALU_RSH  = 5'h0A;
   localparam logic [4:0] ALU_NOP  = 5'h1F;

   localparam int unsigned FLAG_C = 4;
   localparam int unsigned FLAG_L = 3;
   localparam int unsigned FLAG_F = 2;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_N = 0;

   // op field [15:12]
   localparam logic [3:0] OP_REG   = 4'h0;
   localparam logic [3:0] OP_ADDI  = 4'h5;
   localparam logic [3:0] OP_ADDUI = 4'h6;
   localparam logic [3:0] OP_ADDCI = 4'h7;
   localparam logic [3:0] OP_SHIFT = 4'h8;
   localparam logic [3:0] OP_SUBI  = 4'h9;
   localparam logic [3:0] OP_CMPI  = 4'hB;

   // ext field [7:4] under OP_REG
   localparam logic [3:0] EXT_AND  = 4'h1;
   localparam logic [3:0] EXT_OR   = 4'h2;
   localparam logic [3:0] EXT_XOR  = 4'h3;
   localparam logic [3:0] EXT_ADD  = 4'h5;
   localparam logic [3:0] EXT_ADDU = 4'h6;
   localparam logic [3:0] EXT_ADDC = 4'h7;
   localparam logic [3:0] EXT_SUB  = 4'h9;
   localparam logic [3:0] EXT_CMP  = 4'hB;
   localparam logic [3:0] EXT_NOT  = 4'hF;

   // ext field [7:4] under OP_SHIFT
   localparam logic [3:0] EXT_LSHI = 4'h0;
   localparam logic [3:0] EXT_RSHI = 4'h1;
   localparam logic [3:0] EXT_LSH  = 4'h4;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

   typedef enum logic [1:0] {SRC_REG, SRC_SEXT8, SRC_ZEXT8, SRC_ZEXT4} src_sel_t;

   typedef enum logic [1:0] {PSR_KEEP, PSR_ARITH, PSR_CMP} psr_upd_t;

   function automatic logic [4:0] psr_mask(input psr_upd_t upd);
      logic [4:0] m;
      m = '0;
      case (upd)
         PSR_ARITH: begin
            m[FLAG_C] = 1'b1;
            m[FLAG_F] = 1'b1;
         end
         PSR_CMP: begin
            m[FLAG_L] = 1'b1;
            m[FLAG_Z] = 1'b1;
            m[FLAG_N] = 1'b1;
         end
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake plus ALU operand/result bus of the issue controller.
//   instr_valid/instr/instr_ready : valid/ready instruction channel
//   alu_rdest/alu_rsrc/alu_opcode/alu_cin : operands and control to the ALU
//   alu_out/alu_flags : result and {C,L,F,Z,N} flags back from the ALU
// Modports: slave = controller side, master = instruction source + ALU side.
interface alu_issue_ctrl_if #(
   parameter int unsigned REG_W = 16
);
   logic              instr_valid;
   logic [15:0]       instr;
   logic              instr_ready;
   logic [REG_W-1:0]  alu_rdest;
   logic [REG_W-1:0]  alu_rsrc;
   logic [4:0]        alu_opcode;
   logic              alu_cin;
   logic [REG_W-1:0]  alu_out;
   logic [4:0]        alu_flags;

   modport slave (
      input  instr_valid, instr, alu_out, alu_flags,
      output instr_ready, alu_rdest, alu_rsrc, alu_opcode, alu_cin
   );

   modport master (
      output instr_valid, instr, alu_out, alu_flags,
      input  instr_ready, alu_rdest, alu_rsrc, alu_opcode, alu_cin
   );
endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// regfile16x16: NREGS x REG_W register file.
//   clk, reset       : clock, synchronous active-high clear of every entry
//   we/waddr/wdata   : single synchronous write port
//   ra_addr/ra_data  : combinational read port A (Rdest operand)
//   rb_addr/rb_data  : combinational read port B (Rsrc operand)
//   dbg_addr/dbg_data: combinational debug read port
// Reads see the old contents during a write cycle; new data appears after the edge.
module regfile16x16 #(
   parameter int unsigned REG_W = 16,
   parameter int unsigned NREGS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [3:0]       waddr,
   input  logic [REG_W-1:0] wdata,
   input  logic [3:0]       ra_addr,
   output logic [REG_W-1:0] ra_data,
   input  logic [3:0]       rb_addr,
   output logic [REG_W-1:0] rb_data,
   input  logic [3:0]       dbg_addr,
   output logic [REG_W-1:0] dbg_data
);

   logic [REG_W-1:0] mem [NREGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign ra_data  = mem[ra_addr];
   assign rb_data  = mem[rb_addr];
   assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues CR16-style instructions to a 16-bit ALU.
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : instruction valid/ready channel and ALU operand/result bus
//   wb_en/wb_addr/wb_data : register write, valid during the WB cycle
//   psr               : processor status {C,L,F,Z,N}
//   illegal           : one-cycle pulse in EXEC for an undecodable word
//   rd_addr/rd_data   : combinational debug read of the register file
// Three-state sequence IDLE -> EXEC -> WB, one instruction per three cycles.
module alu_issue_ctrl
   import cr16_pkg::*;
#(
   parameter int unsigned REG_W = 16,
   parameter int unsigned NREGS = 16
) (
   input  logic               clk,
   input  logic               reset,
   alu_issue_ctrl_if.slave    bus,
   output logic               wb_en,
   output logic [3:0]         wb_addr,
   output logic [REG_W-1:0]   wb_data,
   output logic [4:0]         psr,
   output logic               illegal,
   input  logic [3:0]         rd_addr,
   output logic [REG_W-1:0]   rd_data
);

   state_t           state;
   logic             wr_q;      // instruction writes Rdest
   psr_upd_t         psr_upd_q; // PSR bits the instruction may change
   logic [4:0]       flags_q;   // ALU flags captured at end of EXEC

   logic [3:0]       f_op, f_ext, f_rdest, f_rsrc;
   logic [REG_W-1:0] rdest_val, rsrc_val, src_val;

   logic [4:0]       dec_op;
   src_sel_t         dec_src;
   psr_upd_t         dec_psr;
   logic             dec_wr;
   logic             dec_ill;

   assign f_op    = bus.instr[15:12];
   assign f_rdest = bus.instr[11:8];
   assign f_ext   = bus.instr[7:4];
   assign f_rsrc  = bus.instr[3:0];

   regfile16x16 #(
      .REG_W(REG_W),
      .NREGS(NREGS)
   ) u_rf (
      .clk      (clk),
      .reset    (reset),
      .we       (wb_en),
      .waddr    (wb_addr),
      .wdata    (wb_data),
      .ra_addr  (f_rdest),
      .ra_data  (rdest_val),
      .rb_addr  (f_rsrc),
      .rb_data  (rsrc_val),
      .dbg_addr (rd_addr),
      .dbg_data (rd_data)
   );

   always_comb begin
      dec_op  = ALU_NOP;
      dec_src = SRC_REG;
      dec_psr = PSR_KEEP;
      dec_wr  = 1'b1;
      dec_ill = 1'b0;
      case (f_op)
         OP_REG: begin
            case (f_ext)
               EXT_ADD:  begin dec_op = ALU_ADD;  dec_psr = PSR_ARITH; end
               EXT_ADDU: begin dec_op = ALU_ADDU; dec_psr = PSR_ARITH; end
               EXT_ADDC: begin dec_op = ALU_ADDC; dec_psr = PSR_ARITH; end
               EXT_SUB:  begin dec_op = ALU_SUB;  dec_psr = PSR_ARITH; end
               EXT_CMP:  begin dec_op = ALU_CMP;  dec_psr = PSR_CMP; dec_wr = 1'b0; end
               EXT_AND:  dec_op = ALU_AND;
               EXT_OR:   dec_op = ALU_OR;
               EXT_XOR:  dec_op = ALU_XOR;
               EXT_NOT:  dec_op = ALU_NOT;
               default:  dec_ill = 1'b1;
            endcase
         end
         OP_ADDI:  begin dec_op = ALU_ADD;  dec_src = SRC_SEXT8; dec_psr = PSR_ARITH; end
         OP_ADDUI: begin dec_op = ALU_ADDU; dec_src = SRC_ZEXT8; dec_psr = PSR_ARITH; end
         OP_ADDCI: begin dec_op = ALU_ADDC; dec_src = SRC_SEXT8; dec_psr = PSR_ARITH; end
         OP_SUBI:  begin dec_op = ALU_SUB;  dec_src = SRC_SEXT8; dec_psr = PSR_ARITH; end
         OP_CMPI:  begin
            dec_op  = ALU_CMP;
            dec_src = SRC_SEXT8;
            dec_psr = PSR_CMP;
            dec_wr  = 1'b0;
         end
         OP_SHIFT: begin
            case (f_ext)
               EXT_LSH:  dec_op = ALU_LSH;
               EXT_LSHI: begin dec_op = ALU_LSH; dec_src = SRC_ZEXT4; end
               EXT_RSHI: begin dec_op = ALU_RSH; dec_src = SRC_ZEXT4; end
               default:  dec_ill = 1'b1;
            endcase
         end
         default: dec_ill = 1'b1;
      endcase
      // An undecodable word becomes a NOP with no side effects at all.
      if (dec_ill) begin
         dec_op  = ALU_NOP;
         dec_src = SRC_REG;
         dec_psr = PSR_KEEP;
         dec_wr  = 1'b0;
      end
   end

   always_comb begin
      src_val = rsrc_val;
      case (dec_src)
         SRC_SEXT8: src_val = {{(REG_W-8){bus.instr[7]}}, bus.instr[7:0]};
         SRC_ZEXT8: src_val = {{(REG_W-8){1'b0}}, bus.instr[7:0]};
         SRC_ZEXT4: src_val = {{(REG_W-4){1'b0}}, bus.instr[3:0]};
         default:   src_val = rsrc_val;
      endcase
   end

   // Ready is combinational so it is low throughout reset and high in the
   // very first cycle after reset falls.
   assign bus.instr_ready = (state == S_IDLE) && !reset;
   assign bus.alu_cin     = psr[FLAG_C];

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         bus.alu_rdest  <= '0;
         bus.alu_rsrc   <= '0;
         bus.alu_opcode <= ALU_NOP;
         wr_q           <= 1'b0;
         psr_upd_q      <= PSR_KEEP;
         flags_q        <= '0;
         wb_en          <= 1'b0;
         wb_addr        <= '0;
         wb_data        <= '0;
         psr            <= '0;
         illegal        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.instr_valid) begin
                  bus.alu_rdest  <= rdest_val;
                  bus.alu_rsrc   <= src_val;
                  bus.alu_opcode <= dec_op;
                  wb_addr        <= f_rdest;
                  wr_q           <= dec_wr;
                  psr_upd_q      <= dec_psr;
                  illegal        <= dec_ill;
                  state          <= S_EXEC;
               end
            end
            S_EXEC: begin
               illegal <= 1'b0;
               wb_data <= bus.alu_out;
               flags_q <= bus.alu_flags;
               wb_en   <= wr_q;
               state   <= S_WB;
            end
            S_WB: begin
               wb_en <= 1'b0;
               psr   <= (psr & ~psr_mask(psr_upd_q)) | (flags_q & psr_mask(psr_upd_q));
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
